// File: rtl/ble_ctrl_types_pkg.sv
// Shared types for the BLE controller FSM: state encoding, mux selects,
// error codes and the per-state mux-select map.
package ble_ctrl_types_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'b000,
    PROGRAMMING   = 3'b001,
    SETUP         = 3'b010,
    ADVERTISEMENT = 3'b011,
    CONNECTED     = 3'b100,
    ERROR_ACK     = 3'b101
  } ble_ctrl_state_t;

  typedef enum logic [1:0] {
    UNSUPPORTED_RX = 2'd0,
    CMD_MEM_RX     = 2'd1,
    BLE_SETUP_RX   = 2'd2,
    CONN_MON_RX    = 2'd3
  } mux_rx_t;

  typedef enum logic {
    BLE_CONTROLLER_TX = 1'b0,
    BLE_SETUP_TX      = 1'b1
  } mux_tx_t;

  typedef enum logic {
    SETUP_TC     = 1'b0,
    PROCESSOR_TC = 1'b1
  } mux_transceiver_t;

  // Prefixed so the SETUP code does not collide with the SETUP state literal.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PROG    = 2'd1,
    ERR_SETUP   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } ble_err_code_t;

  typedef struct packed {
    mux_rx_t          rx;
    mux_tx_t          tx;
    mux_transceiver_t tc;
  } mux_sel_t;

  localparam mux_sel_t MUX_IDLE = '{rx: UNSUPPORTED_RX, tx: BLE_CONTROLLER_TX, tc: SETUP_TC};

  // Mux selects that belong to each state; unused encodings get the idle routing.
  function automatic mux_sel_t mux_map(input ble_ctrl_state_t s);
    mux_sel_t m;
    m = MUX_IDLE;
    case (s)
      PROGRAMMING:   m.rx = CMD_MEM_RX;
      SETUP: begin
        m.rx = BLE_SETUP_RX;
        m.tx = BLE_SETUP_TX;
      end
      ADVERTISEMENT: m.rx = CONN_MON_RX;
      CONNECTED: begin
        m.rx = CONN_MON_RX;
        m.tc = PROCESSOR_TC;
      end
      default:       m = MUX_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ble_ctrl_fsm_if.sv
// Control/status bundle between the BLE controller FSM and its surroundings.
interface ble_ctrl_fsm_if;
  import ble_ctrl_types_pkg::*;

  logic             prog_req_i;
  logic             wake_i;
  logic             sleep_req_i;
  logic             prog_done_i;
  logic             prog_err_i;
  logic             setup_done_i;
  logic             setup_err_i;
  logic             conn_evt_i;
  logic             disconn_evt_i;
  logic             err_ack_i;

  ble_ctrl_state_t  state_o;
  mux_rx_t          mux_rx_o;
  mux_tx_t          mux_tx_o;
  mux_transceiver_t mux_tc_o;
  logic             setup_start_o;
  logic             error_o;
  ble_err_code_t    err_code_o;

  // Host / engines side.
  modport master (
    output prog_req_i, wake_i, sleep_req_i, prog_done_i, prog_err_i,
           setup_done_i, setup_err_i, conn_evt_i, disconn_evt_i, err_ack_i,
    input  state_o, mux_rx_o, mux_tx_o, mux_tc_o, setup_start_o, error_o, err_code_o
  );

  // Controller FSM side.
  modport slave (
    input  prog_req_i, wake_i, sleep_req_i, prog_done_i, prog_err_i,
           setup_done_i, setup_err_i, conn_evt_i, disconn_evt_i, err_ack_i,
    output state_o, mux_rx_o, mux_tx_o, mux_tc_o, setup_start_o, error_o, err_code_o
  );
endinterface

// File: rtl/ble_ctrl_timer.sv
// Saturating dwell counter with a terminal-count compare against limit.
module ble_ctrl_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;

  // Count while enabled, clear on state entry, hold at all-ones.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == limit);

endmodule

// File: rtl/ble_ctrl_fsm.sv
// BLE controller top-level FSM: sequences programming, setup, advertising and
// connection, drives registered mux selects and reports errors to the host.
module ble_ctrl_fsm
  import ble_ctrl_types_pkg::*;
#(
  parameter int SETUP_TIMEOUT = 1000,
  parameter int ADV_TIMEOUT   = 100000
) (
  input logic           clk,
  input logic           rst_n,
  ble_ctrl_fsm_if.slave bus
);

  localparam int MAX_TIMEOUT = (SETUP_TIMEOUT > ADV_TIMEOUT) ? SETUP_TIMEOUT : ADV_TIMEOUT;
  localparam int CNT_W       = (MAX_TIMEOUT > 1) ? $clog2(MAX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] SETUP_LIMIT = CNT_W'(SETUP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ADV_LIMIT   = CNT_W'(ADV_TIMEOUT - 1);

  ble_ctrl_state_t state_q, state_d;
  ble_err_code_t   err_code_q, err_code_d;
  mux_sel_t        mux_q;
  logic            setup_start_q;
  logic            error_q;

  logic             tmr_clr, tmr_en, tmr_expired;
  logic [CNT_W-1:0] tmr_limit;

  // Dwell timer runs only in the two time-limited states and restarts on any state change.
  assign tmr_en    = (state_q == SETUP) || (state_q == ADVERTISEMENT);
  assign tmr_limit = (state_q == SETUP) ? SETUP_LIMIT : ADV_LIMIT;
  assign tmr_clr   = (state_d != state_q);

  ble_ctrl_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  // Next-state and next error-code selection with the per-state priorities.
  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (bus.prog_req_i)  state_d = PROGRAMMING;
        else if (bus.wake_i) state_d = SETUP;
      end
      PROGRAMMING: begin
        if (bus.prog_err_i) begin
          state_d    = ERROR_ACK;
          err_code_d = ERR_PROG;
        end else if (bus.prog_done_i) begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (bus.setup_err_i) begin
          state_d    = ERROR_ACK;
          err_code_d = ERR_SETUP;
        end else if (tmr_expired) begin
          state_d    = ERROR_ACK;
          err_code_d = ERR_TIMEOUT;
        end else if (bus.setup_done_i) begin
          state_d = ADVERTISEMENT;
        end
      end
      ADVERTISEMENT: begin
        if (bus.sleep_req_i)     state_d = IDLE;
        else if (bus.conn_evt_i) state_d = CONNECTED;
        else if (tmr_expired)    state_d = IDLE;
      end
      CONNECTED: begin
        if (bus.sleep_req_i)        state_d = IDLE;
        else if (bus.disconn_evt_i) state_d = ADVERTISEMENT;
      end
      ERROR_ACK: begin
        if (bus.err_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and all outputs register on the same edge so the muxes never lag the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mux_q         <= MUX_IDLE;
      setup_start_q <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      mux_q         <= mux_map(state_d);
      setup_start_q <= (state_d == SETUP) && (state_q != SETUP);
      error_q       <= (state_d == ERROR_ACK);
      err_code_q    <= err_code_d;
    end
  end

  assign bus.state_o       = state_q;
  assign bus.mux_rx_o      = mux_q.rx;
  assign bus.mux_tx_o      = mux_q.tx;
  assign bus.mux_tc_o      = mux_q.tc;
  assign bus.setup_start_o = setup_start_q;
  assign bus.error_o       = error_q;
  assign bus.err_code_o    = err_code_q;

endmodule
